// File: rtl/clk_period_meas_pkg.sv
// Shared types, default widths and the tolerance-compare helper for clk_period_meas.
package clk_period_meas_pkg;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_TIMEOUT     = 1000;
    localparam int DEF_ERR_W       = 8;

    // One bit wider than the largest supported counter so the difference never wraps.
    localparam int DIFF_W = 33;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_e;

    function automatic logic [DIFF_W-1:0] abs_diff(input logic [DIFF_W-1:0] a,
                                                   input logic [DIFF_W-1:0] b);
        logic [DIFF_W-1:0] r;
        if (a >= b) begin
            r = a - b;
        end else begin
            r = b - a;
        end
        return r;
    endfunction

endpackage

// File: rtl/clk_period_meas_sync_edge_det.sv
// Multi-stage synchronizer for an asynchronous level plus a registered rising-edge pulse.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic [STAGES-1:0] sync_r;
    logic              prev_r;

    // Synchronizer chain, delayed copy and edge pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {STAGES{1'b0}};
            prev_r <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], din};
            prev_r <= sync_r[STAGES-1];
            pulse  <= sync_r[STAGES-1] & ~prev_r;
        end
    end

endmodule

// File: rtl/clk_period_meas.sv
// Clock-period monitor: measures mon_in period in clk cycles and checks it against exp +/- tol.
// Optional min/max period tracking is compiled in when PERIOD_MINMAX_EN is defined.
module clk_period_meas
    import clk_period_meas_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int ERR_W       = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             mon_in,
    input  logic [CNT_W-1:0] exp_period,
    input  logic [CNT_W-1:0] tolerance,
    output logic [CNT_W-1:0] period_o,
    output logic             period_vld,
    output logic             pass_o,
    output logic             timeout_o,
    output logic [ERR_W-1:0] err_cnt
`ifdef PERIOD_MINMAX_EN
    ,
    output logic [CNT_W-1:0] min_period_o,
    output logic [CNT_W-1:0] max_period_o
`endif
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_ARM   = CNT_W'(TIMEOUT - 1);
    localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    state_e             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   exp_r;
    logic [CNT_W-1:0]   tol_r;
    logic               edge_s;
    logic [DIFF_W-1:0]  diff_s;
    logic               within_s;

    function automatic logic [ERR_W-1:0] err_inc(input logic [ERR_W-1:0] v);
        return (v == ERR_MAX) ? v : v + ERR_ONE;
    endfunction

    sync_edge_det #(
        .STAGES (SYNC_STAGES)
    ) u_mon_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (mon_in),
        .pulse (edge_s)
    );

    assign diff_s   = abs_diff(DIFF_W'(cnt_r), DIFF_W'(exp_r));
    assign within_s = (diff_s <= DIFF_W'(tol_r));

    // Monitor FSM: arm on the first edge, then measure and check every period, flagging timeouts.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= CNT_ZERO;
            exp_r      <= CNT_ZERO;
            tol_r      <= CNT_ZERO;
            period_o   <= CNT_ZERO;
            period_vld <= 1'b0;
            pass_o     <= 1'b0;
            timeout_o  <= 1'b0;
            err_cnt    <= {ERR_W{1'b0}};
`ifdef PERIOD_MINMAX_EN
            min_period_o <= CNT_MAX;
            max_period_o <= CNT_ZERO;
`endif
        end else begin
            period_vld <= 1'b0;
            timeout_o  <= 1'b0;
            if (!enable) begin
                state_r <= IDLE;
                cnt_r   <= CNT_ZERO;
            end else begin
                case (state_r)
                    IDLE: begin
                        exp_r   <= exp_period;
                        tol_r   <= tolerance;
                        cnt_r   <= CNT_ZERO;
                        state_r <= ARM;
`ifdef PERIOD_MINMAX_EN
                        min_period_o <= CNT_MAX;
                        max_period_o <= CNT_ZERO;
`endif
                    end
                    ARM: begin
                        if (edge_s) begin
                            cnt_r   <= CNT_ONE;
                            state_r <= MEAS;
                        end else if (cnt_r >= TO_ARM) begin
                            timeout_o <= 1'b1;
                            err_cnt   <= err_inc(err_cnt);
                            cnt_r     <= CNT_ZERO;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                    MEAS: begin
                        // An edge takes priority over a simultaneous timeout.
                        if (edge_s) begin
                            period_o   <= cnt_r;
                            period_vld <= 1'b1;
                            pass_o     <= within_s;
                            cnt_r      <= CNT_ONE;
                            if (!within_s) begin
                                err_cnt <= err_inc(err_cnt);
                            end else begin
                                err_cnt <= err_cnt;
                            end
`ifdef PERIOD_MINMAX_EN
                            min_period_o <= (cnt_r < min_period_o) ? cnt_r : min_period_o;
                            max_period_o <= (cnt_r > max_period_o) ? cnt_r : max_period_o;
`endif
                        end else if (cnt_r >= TO_VAL) begin
                            timeout_o <= 1'b1;
                            err_cnt   <= err_inc(err_cnt);
                            cnt_r     <= CNT_ZERO;
                            state_r   <= ARM;
                        end else if (cnt_r != CNT_MAX) begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end else begin
                            cnt_r <= cnt_r;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        cnt_r   <= CNT_ZERO;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_period_meas.sv
// Self-checking bench for clk_period_meas: timestamp-based reference model plus directed scenarios.
module tb_clk_period_meas;

    localparam int CW   = 16;
    localparam int SS   = 2;
    localparam int TO   = 100;
    localparam int EW   = 4;
    localparam int MAXC = 20000;
    localparam int MAXV = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          mon_in;
    logic [CW-1:0] exp_period;
    logic [CW-1:0] tolerance;
    logic [CW-1:0] period_o;
    logic          period_vld;
    logic          pass_o;
    logic          timeout_o;
    logic [EW-1:0] err_cnt;
`ifdef PERIOD_MINMAX_EN
    logic [CW-1:0] min_period_o;
    logic [CW-1:0] max_period_o;
`endif

    always #5 clk = ~clk;

    clk_period_meas #(
        .CNT_W       (CW),
        .SYNC_STAGES (SS),
        .TIMEOUT     (TO),
        .ERR_W       (EW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .mon_in       (mon_in),
        .exp_period   (exp_period),
        .tolerance    (tolerance),
        .period_o     (period_o),
        .period_vld   (period_vld),
        .pass_o       (pass_o),
        .timeout_o    (timeout_o),
        .err_cnt      (err_cnt)
`ifdef PERIOD_MINMAX_EN
        ,
        .min_period_o (min_period_o),
        .max_period_o (max_period_o)
`endif
    );

    // Reference model: works on posedge timestamps. An edge is seen by the monitor SS+1 posedges
    // after the posedge that first samples mon_in high; periods are differences of those stamps.
    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_MEAS = 2;

    bit hist [0:MAXC];
    bit rlog [0:MAXC];
    int m_p = 0;
    int m_mode = M_IDLE;
    int m_wait0, m_last, m_exp, m_tol, m_d;
    int m_period = 0, m_err = 0, m_min = MAXV, m_max = 0;
    bit m_vld = 1'b0, m_to = 1'b0, m_pass = 1'b0, m_ok = 1'b0, m_edge;

    always @(posedge clk) begin
        m_p = m_p + 1;
        hist[m_p] = (rst === 1'b1) ? 1'b0 : (mon_in === 1'b1);
        rlog[m_p] = (rst === 1'b1);
        m_edge = 1'b0;
        if (m_p >= SS + 2) begin
            m_edge = hist[m_p-SS-1] && !hist[m_p-SS-2];
            for (int j = m_p - SS; j <= m_p; j++) begin
                if (rlog[j]) m_edge = 1'b0;
            end
        end
        m_vld = 1'b0;
        m_to  = 1'b0;
        if (rst === 1'b1) begin
            m_ok = 1'b1; m_mode = M_IDLE; m_period = 0; m_pass = 1'b0;
            m_err = 0; m_min = MAXV; m_max = 0;
        end else if (enable !== 1'b1) begin
            m_mode = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            m_exp = int'(exp_period); m_tol = int'(tolerance);
            m_min = MAXV; m_max = 0;
            m_wait0 = m_p + 1; m_mode = M_WAIT;
        end else if (m_mode == M_WAIT) begin
            if (m_edge) begin
                m_last = m_p; m_mode = M_MEAS;
            end else if (m_p - m_wait0 + 1 >= TO) begin
                m_to = 1'b1; if (m_err < (1 << EW) - 1) m_err++;
                m_wait0 = m_p + 1;
            end
        end else begin
            if (m_edge) begin
                m_period = m_p - m_last; m_vld = 1'b1;
                m_d = m_period - m_exp; if (m_d < 0) m_d = -m_d;
                m_pass = (m_d <= m_tol);
                if (!m_pass && m_err < (1 << EW) - 1) m_err++;
                if (m_period < m_min) m_min = m_period;
                if (m_period > m_max) m_max = m_period;
                m_last = m_p;
            end else if (m_p - m_last >= TO) begin
                m_to = 1'b1; if (m_err < (1 << EW) - 1) m_err++;
                m_mode = M_WAIT; m_wait0 = m_p + 1;
            end
        end
    end

    // Requests from the stimulus process, served by the compare process.
    int    lit_req = 0, lit_id = 0, lit_exp = 0, clr_req = 0;
    string lit_nm = "";

    int total = 0, bad = 0;
    int lit_done = 0, clr_done = 0;
    int vld_seen = 0, to_seen = 0, first_to = -1;
    logic [31:0] la;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: actual=%0d expected=%0d (posedge %0d)", nm, act, expv, m_p);
        end
    endtask

    // Compare process: DUT against the model every cycle, event counters, and literal checks.
    always @(negedge clk) begin
        if (clr_req != clr_done) begin
            clr_done = clr_req; vld_seen = 0; to_seen = 0; first_to = -1;
        end
        if (m_ok) begin
            cmp("period_o",   32'(period_o),   32'(m_period));
            cmp("period_vld", 32'(period_vld), 32'(m_vld));
            cmp("pass_o",     32'(pass_o),     32'(m_pass));
            cmp("timeout_o",  32'(timeout_o),  32'(m_to));
            cmp("err_cnt",    32'(err_cnt),    32'(m_err));
`ifdef PERIOD_MINMAX_EN
            cmp("min_period", 32'(min_period_o), 32'(m_min));
            cmp("max_period", 32'(max_period_o), 32'(m_max));
`endif
            if (period_vld === 1'b1) vld_seen++;
            if (timeout_o === 1'b1) begin
                to_seen++;
                if (first_to < 0) first_to = m_p;
            end
        end
        if (lit_req != lit_done) begin
            lit_done = lit_req;
            case (lit_id)
                0:  la = 32'(period_o);
                1:  la = 32'(pass_o);
                2:  la = 32'(err_cnt);
                3:  la = 32'(vld_seen);
                4:  la = 32'(to_seen);
                5:  la = 32'(first_to);
`ifdef PERIOD_MINMAX_EN
                6:  la = 32'(min_period_o);
                7:  la = 32'(max_period_o);
`endif
                8:  la = 32'(period_vld);
                9:  la = 32'(timeout_o);
                10: la = 32'(m_period);
                default: la = 32'hDEAD_BEEF;
            endcase
            cmp(lit_nm, la, 32'(lit_exp));
        end
    end

    task automatic lit(input int id, input string nm, input int expv);
        #1;
        lit_id = id; lit_nm = nm; lit_exp = expv; lit_req++;
        @(negedge clk);
    endtask

    task automatic clr();
        #1;
        clr_req++;
        @(negedge clk);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    int last_rise = 0;

    // One mon_in period of P clk cycles, rising first.
    task automatic per(input int p);
        mon_in = 1'b1;
        last_rise = m_p + 1;
        tick(p / 2);
        mon_in = 1'b0;
        tick(p - p / 2);
    endtask

    task automatic start(input logic [CW-1:0] e, input logic [CW-1:0] t);
        enable = 1'b0;
        tick(4);
        exp_period = e;
        tolerance  = t;
        enable = 1'b1;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; mon_in = 1'b0;
        exp_period = 16'd0; tolerance = 16'd0;
        tick(3);
        rst = 1'b0;
        lit(0, "rst_period", 0);
        lit(1, "rst_pass", 0);
        lit(2, "rst_err", 0);
        lit(8, "rst_vld", 0);
        lit(9, "rst_timeout", 0);

        // Nominal: period 36, exact match.
        clr();
        start(16'd36, 16'd0);
        repeat (6) per(36);
        enable = 1'b0; tick(2);
        lit(0, "nom_period", 36);
        lit(1, "nom_pass", 1);
        lit(2, "nom_err", 0);
        lit(3, "nom_vld_count", 5);
        lit(10, "model_period", 36);

        // Wrong expectation: every period fails.
        clr();
        start(16'd20, 16'd0);
        repeat (4) per(36);
        enable = 1'b0; tick(2);
        lit(0, "fail_period", 36);
        lit(1, "fail_pass", 0);
        lit(2, "fail_err", 3);
        lit(3, "fail_vld_count", 3);

        // Tolerance boundary: 34 and 38 pass, 39 fails.
        clr();
        start(16'd36, 16'd2);
        per(34); per(38); per(39); per(39);
        enable = 1'b0; tick(2);
        lit(0, "tol_period", 39);
        lit(1, "tol_pass", 0);
        lit(2, "tol_err", 4);
        lit(3, "tol_vld_count", 3);

        // Stuck low: MEAS timeout then one ARM timeout, then resume.
        clr();
        start(16'd36, 16'd0);
        repeat (4) per(36);
        tick(240);
        lit(4, "to_count", 2);
        lit(5, "to_first_posedge", last_rise + SS + 1 + TO);
        lit(2, "to_err", 6);
        clr();
        repeat (3) per(36);
        lit(3, "resume_vld_count", 2);
        lit(4, "resume_to_count", 0);
        lit(0, "resume_period", 36);
        enable = 1'b0; tick(2);

        // Reset in the middle of a measurement.
        start(16'd36, 16'd0);
        per(36); per(36);
        mon_in = 1'b1; tick(18);
        mon_in = 1'b0; tick(2);
        rst = 1'b1; tick(1);
        rst = 1'b0;
        clr();
        lit(0, "mrst_period", 0);
        lit(2, "mrst_err", 0);
        lit(1, "mrst_pass", 0);
        tick(12);
        repeat (3) per(36);
        lit(3, "mrst_vld_count", 2);
        lit(0, "mrst_period2", 36);
        lit(2, "mrst_err2", 0);

        // Enable dropped on the very cycle the edge reaches the FSM.
        enable = 1'b0; tick(2);
        start(16'd36, 16'd0);
        repeat (3) per(36);
        clr();
        mon_in = 1'b1;
        tick(3);
        enable = 1'b0;
        tick(15);
        mon_in = 1'b0;
        tick(150);
        lit(3, "drop_vld_count", 0);
        lit(0, "drop_period", 36);
        lit(1, "drop_pass", 1);
        lit(4, "drop_to_count", 0);

        // Varying periods for min/max tracking.
        start(16'd36, 16'd0);
        per(36); per(34); per(40); per(36);
        enable = 1'b0; tick(2);
        lit(0, "mm_period", 40);
        lit(2, "mm_err", 2);
`ifdef PERIOD_MINMAX_EN
        lit(6, "mm_min", 34);
        lit(7, "mm_max", 40);
`endif

        // Shortest period, tolerance equal to expectation.
        clr();
        start(16'd5, 16'd5);
        repeat (5) per(2);
        tick(2);
        enable = 1'b0; tick(2);
        lit(0, "short_period", 2);
        lit(1, "short_pass", 1);
        lit(3, "short_vld_count", 4);
`ifdef PERIOD_MINMAX_EN
        lit(6, "short_min", 2);
        lit(7, "short_max", 2);
`endif

        // Error counter saturation.
        start(16'd20, 16'd0);
        repeat (16) per(36);
        enable = 1'b0; tick(2);
        lit(2, "sat_err", 15);
        lit(1, "sat_pass", 0);

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
